// File: rtl/soc_pkg.sv
// Shared SoC types: default bus widths plus the arbiter's state and owner encodings.
package soc_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: req[0] is fetch, req[1] is data; one-hot grant.
module rr_pick2
  import soc_pkg::*;
(
  input  logic   [1:0] req,
  input  owner_e       last,
  output logic   [1:0] grant
);

  always_comb begin
    grant = req;
    // On contention the side that did not win last time goes next.
    if (req == 2'b11) begin
      grant = (last == OWN_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency synchronous memory port between the fetch and load/store ports,
// one outstanding transaction at a time, round-robin on contention.
module mem_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ready,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_ready,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Owner of the in-flight transaction; also serves as the round-robin history.
  owner_e           last_q, last_d;
  logic             we_q, we_d;
  logic [1:0]       grant;

  rr_pick2 u_pick (
    .req   ({d_req, i_req}),
    .last  (last_q),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= OWN_I;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    we_d      = we_q;
    i_ready   = 1'b0;
    i_valid   = 1'b0;
    i_rdata   = '0;
    d_ready   = 1'b0;
    d_valid   = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant[1]) begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_wstrb = d_we ? d_wstrb : '0;
          d_ready   = 1'b1;
          last_d    = OWN_D;
          we_d      = d_we;
          cnt_d     = CNT_W'(MEM_LATENCY);
          state_d   = ST_WAIT;
        end else if (grant[0]) begin
          mem_en    = 1'b1;
          mem_addr  = i_addr;
          i_ready   = 1'b1;
          last_d    = OWN_I;
          we_d      = 1'b0;
          cnt_d     = CNT_W'(MEM_LATENCY);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (last_q == OWN_D) begin
            d_valid = 1'b1;
            d_rdata = we_q ? '0 : mem_rdata;
          end else begin
            i_valid = 1'b1;
            i_rdata = mem_rdata;
          end
        end
      end
    endcase

    // Requests are combinational into the grant, so outputs must be forced quiet in reset.
    if (reset) begin
      i_ready   = 1'b0;
      i_valid   = 1'b0;
      i_rdata   = '0;
      d_ready   = 1'b0;
      d_valid   = 1'b0;
      d_rdata   = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at latency 1 and one at latency 3,
// selected by sel and sharing a small memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;

  logic        a_i_ready, a_i_valid, a_d_ready, a_d_valid, a_mem_en, a_mem_we;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_i_ready, b_i_valid, b_d_ready, b_d_valid, b_mem_en, b_mem_we;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;
  logic [31:0] rd_pipe [0:2];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .i_req(i_req & ~sel), .i_addr(i_addr), .i_ready(a_i_ready), .i_valid(a_i_valid), .i_rdata(a_i_rdata),
    .d_req(d_req & ~sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(a_d_ready), .d_valid(a_d_valid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(rd_pipe[0])
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(reset),
    .i_req(i_req & sel), .i_addr(i_addr), .i_ready(b_i_ready), .i_valid(b_i_valid), .i_rdata(b_i_rdata),
    .d_req(d_req & sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(b_d_ready), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(rd_pipe[2])
  );

  logic        i_ready, i_valid, d_ready, d_valid, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  assign i_ready   = sel ? b_i_ready   : a_i_ready;
  assign i_valid   = sel ? b_i_valid   : a_i_valid;
  assign i_rdata   = sel ? b_i_rdata   : a_i_rdata;
  assign d_ready   = sel ? b_d_ready   : a_d_ready;
  assign d_valid   = sel ? b_d_valid   : a_d_valid;
  assign d_rdata   = sel ? b_d_rdata   : a_d_rdata;
  assign mem_en    = sel ? b_mem_en    : a_mem_en;
  assign mem_we    = sel ? b_mem_we    : a_mem_we;
  assign mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign mem_wstrb = sel ? b_mem_wstrb : a_mem_wstrb;

  int cyc = 0;
  logic [31:0] mem [0:255];

  // Memory model: read data leaves stage 0 after one cycle, stage 2 after three; idle filler is nonzero.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_pipe[0] <= 32'h5A5A5A5A;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
    if (cyc == 0) begin
      mem[0]  <= 32'h00100293;
      mem[65] <= 32'hAAAAAAAA;
    end
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rd_pipe[0] <= mem[mem_addr[9:2]];
      end
    end
  end

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gap;
  } gexp_t;
  typedef struct {
    int          port;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int errors = 0, checks = 0, last_g = -100, n_grants = 0;

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    int port, lat;
    lat = sel ? 3 : 1;
    if (!reset) begin
      if (mem_en || i_ready || d_ready) begin
        checks++;
        port = d_ready ? 1 : 0;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got en=%b ir=%b dr=%b addr=%h, want no grant", mem_en, i_ready, d_ready, mem_addr);
        end else begin
          g = gq.pop_front();
          if (!(mem_en && (i_ready ^ d_ready)) || port != g.port || mem_we !== g.we ||
              mem_addr !== g.addr || mem_wstrb !== g.wstrb || (g.we && mem_wdata !== g.wdata) ||
              (g.gap >= 0 && cyc - last_g != g.gap)) begin
            errors++;
            $display("FAIL grant: got en=%b ir=%b dr=%b we=%b addr=%h wdata=%h wstrb=%h gap=%0d, want port=%0d we=%b addr=%h wdata=%h wstrb=%h gap=%0d",
                     mem_en, i_ready, d_ready, mem_we, mem_addr, mem_wdata, mem_wstrb, cyc - last_g,
                     g.port, g.we, g.addr, g.wdata, g.wstrb, g.gap);
          end else begin
            $display("grant  cyc=%0d port=%0d we=%b addr=%h wstrb=%h", cyc, port, mem_we, mem_addr, mem_wstrb);
          end
        end
        last_g = cyc;
        n_grants++;
      end
      checks++;
      if (i_valid || d_valid) begin
        port = d_valid ? 1 : 0;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got iv=%b dv=%b, want no valid", i_valid, d_valid);
        end else begin
          r = rq.pop_front();
          if (!(i_valid ^ d_valid) || port != r.port || (port ? d_rdata : i_rdata) !== r.data ||
              (port ? i_rdata : d_rdata) !== 32'h0 || cyc - last_g != lat) begin
            errors++;
            $display("FAIL resp: got iv=%b dv=%b ird=%h drd=%h lat=%0d, want port=%0d data=%h lat=%0d",
                     i_valid, d_valid, i_rdata, d_rdata, cyc - last_g, r.port, r.data, lat);
          end else begin
            $display("resp   cyc=%0d port=%0d data=%h", cyc, port, r.data);
          end
        end
      end else if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_rdata: got ird=%h drd=%h, want 0", i_rdata, d_rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int gap);
    gexp_t g;
    g.port = port; g.we = we; g.addr = addr; g.wdata = wdata; g.wstrb = wstrb; g.gap = gap;
    gq.push_back(g);
  endtask

  task automatic push_r(input int port, input logic [31:0] data);
    rexp_t r;
    r.port = port; r.data = data;
    rq.push_back(r);
  endtask

  task automatic wait_ready(input int port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port != 0 ? d_ready : i_ready) && n < 40);
    checks++;
    if (!(port != 0 ? d_ready : i_ready)) begin
      errors++;
      $display("FAIL ready_timeout: port=%0d got ready=0 after %0d cycles, want 1", port, n);
    end
  endtask

  // wstrb_exp is the hand-computed strobe the memory must see.
  task automatic do_req(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [3:0] wstrb_exp, input logic [31:0] rdata_exp,
                        input bit resp);
    push_g(port, we, addr, wdata, wstrb_exp, -1);
    if (resp) push_r(port, rdata_exp);
    if (port != 0) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    wait_ready(port);
    step();
    if (port != 0) d_req = 1'b0; else i_req = 1'b0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({i_ready, i_valid, d_ready, d_valid, mem_en, mem_we} !== 6'b0 || i_rdata !== 32'h0 ||
        d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL %s: got ir=%b iv=%b dr=%b dv=%b en=%b we=%b addr=%h wdata=%h wstrb=%h, want all 0",
               name, i_ready, i_valid, d_ready, d_valid, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || gq.size() != 0) && n < 40) begin
      step();
      n++;
    end
    step();
    checks++;
    if (rq.size() != 0 || gq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d grants and %0d responses pending, want 0", gq.size(), rq.size());
    end
  endtask

  initial begin
    int n, n0;
    // Reset with requests asserted: outputs must stay quiet.
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h12345678; d_wstrb = 4'hF; d_we = 1'b1;
    @(negedge clk); check_zero("reset_init_a");
    @(negedge clk); check_zero("reset_init_b");
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Latency 1: fetch, full store/load, partial store/load.
    do_req(0, 1'b0, 32'h0,   32'h0,        4'h0, 4'h0, 32'h00100293, 1'b1);
    do_req(1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 4'hF, 32'h0,        1'b1);
    do_req(1, 1'b0, 32'h100, 32'h0,        4'hF, 4'h0, 32'hDEADBEEF, 1'b1);
    do_req(1, 1'b1, 32'h104, 32'h11223344, 4'h3, 4'h3, 32'h0,        1'b1);
    do_req(1, 1'b0, 32'h104, 32'h0,        4'hF, 4'h0, 32'hAAAA3344, 1'b1);
    do_req(0, 1'b0, 32'h0,   32'h0,        4'h0, 4'h0, 32'h00100293, 1'b1);
    drain();

    // Contention after a fetch grant: D, I, D, I back to back.
    push_g(1, 1'b0, 32'h100, 32'h0, 4'h0, -1); push_r(1, 32'hDEADBEEF);
    push_g(0, 1'b0, 32'h0,   32'h0, 4'h0,  2); push_r(0, 32'h00100293);
    push_g(1, 1'b0, 32'h100, 32'h0, 4'h0,  2); push_r(1, 32'hDEADBEEF);
    push_g(0, 1'b0, 32'h0,   32'h0, 4'h0,  2); push_r(0, 32'h00100293);
    n0 = n_grants;
    i_addr = 32'h0; d_addr = 32'h100; d_we = 1'b0; d_wstrb = 4'hF;
    i_req = 1'b1; d_req = 1'b1;
    n = 0;
    while (n_grants < n0 + 4 && n < 40) begin
      step();
      n++;
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n_grants != n0 + 4) begin
      errors++;
      $display("FAIL contention_count: got %0d grants, want 4", n_grants - n0);
    end
    drain();

    // Latency 3: load, with a fetch raised one cycle after the grant.
    sel = 1'b1;
    step();
    push_g(1, 1'b0, 32'h100, 32'h0, 4'h0, -1); push_r(1, 32'hDEADBEEF);
    push_g(0, 1'b0, 32'h0,   32'h0, 4'h0,  4); push_r(0, 32'h00100293);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wstrb = 4'hF;
    wait_ready(1);
    step();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0;
    wait_ready(0);
    step();
    i_req = 1'b0;
    drain();

    // Reset one cycle into a latency-3 load: its response is dropped, next contention goes to data.
    do_req(1, 1'b0, 32'h100, 32'h0, 4'hF, 4'h0, 32'h0, 1'b0);
    reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0; d_addr = 32'h100; d_we = 1'b0; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'hF;
    push_g(1, 1'b0, 32'h100, 32'h0, 4'h0, -1); push_r(1, 32'hDEADBEEF);
    @(negedge clk); check_zero("reset_mid_a");
    @(negedge clk); check_zero("reset_mid_b");
    step();
    reset = 1'b0;
    wait_ready(1);
    step();
    i_req = 1'b0; d_req = 1'b0;
    drain();
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
